stream_pool: RTL and testbench
==============================

# stream_pool

Streaming, parametrised successor to the combinational max-pool array. It accepts one signed pixel per cycle in raster order over a valid/ready handshake. Non-overlapping POOL_SIZE×POOL_SIZE windows are reduced by max or by average, using a one-row line accumulator instead of a full-frame flattened bus. It sits between a convolution/activation stage and the next layer, and emits pooled values in raster order with an end-of-frame marker.

## Interface
- DATA_WIDTH, 32, pixel width, two's-complement signed
- IMG_SIZE, 28, square input frame side, in pixels
- POOL_SIZE, 2, window side and stride; must be a power of two ≥ 2
- Derived: OUT_SIZE = IMG_SIZE/POOL_SIZE (floor); SH = 2·log2(POOL_SIZE); ACC_W = DATA_WIDTH+SH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- avg_mode  in  1  0 = max, 1 = average; sampled only when pixel (0,0) of a frame is accepted
- in_valid  in  1  pixel present
- in_ready  out  1  block can accept a pixel
- in_data  in  DATA_WIDTH  signed pixel
- out_valid  out  1  pooled result present
- out_ready  in  1  downstream accepts the result
- out_data  out  DATA_WIDTH  signed pooled result
- out_last  out  1  qualifies the final pooled result of a frame, at window (OUT_SIZE-1, OUT_SIZE-1)

## Operation
- Interface decision: one clock; reset is asynchronous and active-low.
- Pixels are transferred on in_valid && in_ready.
- Row/column counters r, c track the position of the next pixel, in raster order.
  - c wraps at IMG_SIZE-1 and increments r.
  - r wraps at IMG_SIZE-1, completing a frame.
  - No frame-start input exists; the counters alone define framing.
- A pixel is in range iff r < OUT_SIZE·POOL_SIZE and c < OUT_SIZE·POOL_SIZE.
  - Out-of-range pixels are accepted and discarded. Their only effect is to advance the counters.
- Line accumulator: OUT_SIZE entries of ACC_W bits, indexed by w = c/POOL_SIZE.
- Mode register: loaded from avg_mode when pixel (0,0) is accepted. A change on avg_mode mid-frame has no effect.
- Window start (r%P==0 and c%P==0): acc[w] ← in_data (sign-extended).
- Interior pixel: acc[w] ← max(acc[w], in_data) in max mode, or acc[w] + in_data in average mode. All comparisons and additions are signed.
- Window end (r%P==P-1 and c%P==P-1):
  - Compute the result from acc[w] combined with the current pixel.
  - Average result = sum >>> SH. This is an arithmetic shift, so it floors toward −∞. The low DATA_WIDTH bits are kept, which is lossless.
  - Load out_data; set out_valid.
  - Set out_last iff r/P == OUT_SIZE-1 and w == OUT_SIZE-1.
  - acc[w] is not written.
- Output register: a single entry. out_valid clears on out_valid && out_ready, unless a new result loads in the same cycle.
- in_ready = !out_valid || out_ready. This is a conservative stall that applies to every pixel, not only window-end pixels.
- Accumulator RAM is not reset. Every entry is initialised by its window-start pixel before it is read.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_last = 0.
  - r = c = 0; mode register = 0.
  - in_ready = 1 once rst_n is high.
- Reset mid-frame aborts the frame: any pending output is dropped, and the next accepted pixel is (0,0).
- Latency: out_valid rises on the clock edge that accepts the window-end pixel, i.e. one cycle after that pixel is presented.
- Throughput: one pixel per cycle while out_ready = 1. Output rate is at most one result per POOL_SIZE input cycles.
- Simultaneous output drain and new result in the same cycle: the new result loads and out_valid stays 1, with no bubble.
- While out_valid && !out_ready:
  - in_ready = 0.
  - out_data and out_last are held stable.
  - The counters and accumulators freeze.
- Last pixel of a frame (r = c = IMG_SIZE-1): the counters return to (0,0) with no idle cycle. The next frame may start on the following cycle.
- out_last is only meaningful when out_valid = 1, and is cleared when the result is consumed.

## Test plan
- Max mode, IMG=4, P=2, pixels 0..15, out_ready=1 → results 5, 7, 13, 15, each one cycle after pixels 5, 7, 13, 15; out_last only with 15.
- Average mode, same stimulus → results 2, 4, 10, 12 (sums 10, 18, 42, 50 >>> 2). Signed window {−1, −2, −2, −2} → −2 (sum −7 floors). Max mode on {−1, −2, −3, −4} → −1.
- Backpressure: hold out_ready=0 for 5 cycles while result 7 is pending → in_ready=0, out_data stays 7, no pixel lost or duplicated; the remaining results are 13 and 15 in order.
- IMG=5, P=2, pixels 0..24 → 4 results, 6, 8, 16, 18; out_last with 18. Pixels 19..24 are accepted with no output. The next frame's pixel 0 initialises a window.
- Assert rst_n low after 6 pixels of a frame, then send a full 4×4 frame → only that frame's 4 correct results appear.
- Toggle avg_mode after pixel 3 of a max-mode frame → all of that frame's results stay max. Averaging takes effect on the next frame.

Source files
------------

// File: rtl/stream_pool.sv
// Streaming POOL_SIZE x POOL_SIZE max/average pooling over a raster pixel stream,
// using a single-row line accumulator and a one-entry output register.
module stream_pool #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 28,
  parameter int POOL_SIZE  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         avg_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam int OUT_SIZE = IMG_SIZE / POOL_SIZE;
  localparam int LP       = $clog2(POOL_SIZE);
  localparam int SH       = 2 * LP;
  localparam int ACC_W    = DATA_WIDTH + SH;
  localparam int CW       = $clog2(IMG_SIZE + 1);
  localparam int WCW      = CW - LP;
  localparam int WW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  localparam logic [CW-1:0]  LAST_PIX = CW'(IMG_SIZE - 1);
  localparam logic [CW-1:0]  SPAN     = CW'(OUT_SIZE * POOL_SIZE);
  localparam logic [WCW-1:0] LAST_WIN = WCW'(OUT_SIZE - 1);

  logic [CW-1:0] r_q, r_d, c_q, c_d;
  logic          mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic signed [ACC_W-1:0] acc_q [OUT_SIZE];
  logic signed [ACC_W-1:0] acc_d, px_ext, acc_rd, combined;
  logic                    acc_we;
  logic [WW-1:0]           w;
  logic fire_in, in_range, win_start, win_end;

  assign in_ready  = !out_valid_q || out_ready;
  assign fire_in   = in_valid && in_ready;
  assign in_range  = (r_q < SPAN) && (c_q < SPAN);
  assign win_start = ~|r_q[LP-1:0] && ~|c_q[LP-1:0];
  assign win_end   = &r_q[LP-1:0] && &c_q[LP-1:0];
  assign w         = WW'(c_q >> LP);
  assign px_ext    = ACC_W'(in_data);
  assign acc_rd    = acc_q[w];

  always_comb begin
    r_d         = r_q;
    c_d         = c_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q && !(out_valid_q && out_ready);
    out_data_d  = out_data_q;
    acc_we      = 1'b0;
    acc_d       = px_ext;

    if (mode_q) combined = acc_rd + px_ext;
    else        combined = (px_ext > acc_rd) ? px_ext : acc_rd;

    if (fire_in) begin
      if (r_q == '0 && c_q == '0) mode_d = avg_mode;

      if (c_q == LAST_PIX) begin
        c_d = '0;
        r_d = (r_q == LAST_PIX) ? '0 : r_q + CW'(1);
      end else begin
        c_d = c_q + CW'(1);
      end

      if (in_range) begin
        if (win_end) begin
          // The window result folds in the current pixel directly; acc[w] is left untouched.
          out_valid_d = 1'b1;
          out_data_d  = mode_q ? DATA_WIDTH'(combined >>> SH) : DATA_WIDTH'(combined);
          out_last_d  = (r_q[CW-1:LP] == LAST_WIN) && (c_q[CW-1:LP] == LAST_WIN);
        end else begin
          acc_we = 1'b1;
          acc_d  = win_start ? px_ext : combined;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      c_q         <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_q         <= r_d;
      c_q         <= c_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: the accumulator row has no reset; every entry is written by its window-start pixel before use.
  always_ff @(posedge clk) begin
    if (acc_we) acc_q[w] <= acc_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_pool.sv
// Randomised self-checking bench for stream_pool (5x5 frame, 2x2 windows) against a
// frame-buffer reference model that pools whole windows with plain arithmetic.
module tb_stream_pool;

  localparam int DW  = 32;
  localparam int IMG = 5;
  localparam int P   = 2;
  localparam int OUT = IMG / P;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 avg_mode = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_data;
  logic                 out_last;

  stream_pool #(.DATA_WIDTH(DW), .IMG_SIZE(IMG), .POOL_SIZE(P)) u_dut (
    .clk(clk), .rst_n(rst_n), .avg_mode(avg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    bit     last;
  } exp_t;

  exp_t   exp_q[$];
  longint frame [IMG][IMG];
  int     mr, mc;
  bit     fmode;
  int     n_tests, n_fail, n_results;
  int     bp_pct, gap_pct;
  bit     stall_pending;
  longint held_data;
  bit     held_last;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: store the frame, and when a window's bottom-right pixel arrives pool it.
  task automatic model_accept(input longint d, input bit m);
    longint best, sum, q;
    int wr, wc;
    if (mr == 0 && mc == 0) fmode = m;
    frame[mr][mc] = d;
    if (mr < OUT * P && mc < OUT * P && mr % P == P - 1 && mc % P == P - 1) begin
      wr = mr / P;
      wc = mc / P;
      best = frame[wr*P][wc*P];
      sum = 0;
      for (int i = 0; i < P; i++)
        for (int j = 0; j < P; j++) begin
          sum += frame[wr*P+i][wc*P+j];
          if (frame[wr*P+i][wc*P+j] > best) best = frame[wr*P+i][wc*P+j];
        end
      q = sum / (P * P);
      if (sum % (P * P) != 0 && sum < 0) q--;
      exp_q.push_back('{data: fmode ? q : best, last: (wr == OUT - 1 && wc == OUT - 1)});
    end
    if (mc == IMG - 1) begin
      mc = 0;
      mr = (mr == IMG - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic consume();
    exp_t e;
    n_results++;
    if (exp_q.size() == 0) begin
      check("unexpected_result", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("out_data", out_data, e.data);
      check("out_last", out_last, e.last);
    end
  endtask

  task automatic step(input bit v, input logic signed [DW-1:0] d, input bit m, output bit acc);
    @(negedge clk);
    if (stall_pending) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, held_data);
      check("hold_last", out_last, held_last);
    end
    in_valid  = v;
    in_data   = d;
    avg_mode  = m;
    out_ready = (bp_pct == 0) ? 1'b1 : ($urandom_range(99) >= bp_pct);
    #1;
    check("in_ready", in_ready, !out_valid || out_ready);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) consume();
    stall_pending = out_valid && !out_ready;
    held_data     = out_data;
    held_last     = out_last;
    if (acc) model_accept(longint'(d), m);
  endtask

  task automatic send_pixel(input logic signed [DW-1:0] d, input bit m);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      if (gap_pct != 0 && $urandom_range(99) < gap_pct) step(1'b0, d, !m, acc);
      else step(1'b1, d, m, acc);
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  // kind: 0 = ramp 0..N, 1 = random, 2 = (0,0)=-1 others -2. mode_sel: 0 fixed, 1 flip after pixel 3, 2 random.
  task automatic send_frame(input int kind, input bit m0, input int mode_sel, input int n_px);
    logic signed [DW-1:0] d;
    bit m;
    for (int k = 0; k < n_px; k++) begin
      case (kind)
        0:       d = DW'(k);
        1:       d = $urandom;
        default: d = (k == 0) ? -1 : -2;
      endcase
      if (k == 0 || mode_sel == 0) m = m0;
      else if (mode_sel == 1)      m = (k <= 3) ? m0 : !m0;
      else                         m = 1'($urandom_range(1));
      send_pixel(d, m);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    exp_q.delete();
    mr = 0;
    mc = 0;
    stall_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
  endtask

  task automatic drain();
    bit acc;
    int n;
    bp_pct = 0;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      step(1'b0, '0, 1'b0, acc);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", out_valid, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_results = 0;
    bp_pct = 0; gap_pct = 0;
    mr = 0; mc = 0; fmode = 1'b0;
    stall_pending = 1'b0;

    #12;
    check("init_out_valid", out_valid, 0);
    check("init_out_data", out_data, 0);
    check("init_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("init_in_ready", in_ready, 1);

    // Directed: ramp frame in max, then in average, signed floor window, mode flip mid-frame.
    send_frame(0, 1'b0, 0, IMG * IMG);
    send_frame(0, 1'b1, 0, IMG * IMG);
    send_frame(2, 1'b1, 0, IMG * IMG);
    send_frame(2, 1'b0, 0, IMG * IMG);
    send_frame(0, 1'b0, 1, IMG * IMG);
    send_frame(0, 1'b1, 0, IMG * IMG);
    drain();
    check("directed_results", n_results, 6 * OUT * OUT);

    // Backpressure with stalls on a ramp frame.
    bp_pct = 50;
    send_frame(0, 1'b0, 0, IMG * IMG);
    drain();

    // Reset mid-frame with a result possibly pending, then a clean frame.
    bp_pct = 30;
    send_frame(1, 1'b0, 2, 8);
    do_reset();
    send_frame(1, 1'b1, 0, IMG * IMG);
    drain();

    // Random data, random mode, random gaps and backpressure, back-to-back frames.
    for (int f = 0; f < 12; f++) begin
      bp_pct  = $urandom_range(60);
      gap_pct = $urandom_range(40);
      send_frame(1, 1'($urandom_range(1)), 2, IMG * IMG);
    end
    gap_pct = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
